// File: rtl/plab3_mem_domain_tdm_arbiter.sv
// Two-domain TDM arbiter in front of the blocking L2. Fixed slots decide which domain may
// issue; one L2 transaction is in flight at a time, and its response is routed back to its owner.
module plab3_mem_domain_tdm_arbiter #(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 128,
    parameter int p_slot_cycles  = 16,
    parameter int p_guard_cycles = 4,
    localparam int len_nbits  = $clog2(p_data_nbits/8),
    localparam int req_nbits  = 3 + p_opaque_nbits + p_addr_nbits + len_nbits + p_data_nbits,
    localparam int resp_nbits = 3 + p_opaque_nbits + len_nbits + p_data_nbits,
    localparam int cnt_nbits  = $clog2(p_slot_cycles)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [req_nbits-1:0]  in0_req_msg,
    input  logic                  in0_req_val,
    output logic                  in0_req_rdy,
    output logic [resp_nbits-1:0] in0_resp_msg,
    output logic                  in0_resp_val,
    input  logic                  in0_resp_rdy,
    input  logic [req_nbits-1:0]  in1_req_msg,
    input  logic                  in1_req_val,
    output logic                  in1_req_rdy,
    output logic [resp_nbits-1:0] in1_resp_msg,
    output logic                  in1_resp_val,
    input  logic                  in1_resp_rdy,
    output logic [req_nbits-1:0]  out_req_msg,
    output logic                  out_req_val,
    input  logic                  out_req_rdy,
    input  logic [resp_nbits-1:0] out_resp_msg,
    input  logic                  out_resp_val,
    output logic                  out_resp_rdy,
    output logic                  sd,
    output logic [1:0]            dbg_state_o,
    output logic [cnt_nbits-1:0]  dbg_slot_cnt_o,
    output logic                  dbg_cur_dom_o
);

    // Handshake: a transfer fires in any cycle where val and rdy are both high; val never
    // depends on rdy of the same channel, and responses pass straight through in WAIT.
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

    localparam logic [cnt_nbits-1:0] slot_last = cnt_nbits'(p_slot_cycles - 1);
    localparam logic [cnt_nbits:0]   win_end   = (cnt_nbits+1)'(p_slot_cycles - p_guard_cycles);

    state_t                 state_q;
    logic [cnt_nbits-1:0]   slot_q, slot_d;
    logic                   cur_dom_q, cur_dom_d;
    logic                   owner_q;
    logic [req_nbits-1:0]   req_q;

    logic win, in_idle, in_issue, in_wait;
    logic own_resp_rdy, accept, resp_fire;
    logic [req_nbits-1:0] cur_req_msg;

    // The slot counter free-runs regardless of transaction state so slot timing never leaks.
    always_comb begin
        slot_d    = slot_q + 1'b1;
        cur_dom_d = cur_dom_q;
        if (slot_q == slot_last) begin
            slot_d    = '0;
            cur_dom_d = ~cur_dom_q;
        end
    end

    assign win      = ({1'b0, slot_q} < win_end);
    assign in_idle  = !reset && (state_q == IDLE);
    assign in_issue = !reset && (state_q == ISSUE);
    assign in_wait  = !reset && (state_q == WAIT);

    assign in0_req_rdy = in_idle && win && !cur_dom_q;
    assign in1_req_rdy = in_idle && win &&  cur_dom_q;
    assign accept      = (in0_req_val && in0_req_rdy) || (in1_req_val && in1_req_rdy);
    assign cur_req_msg = cur_dom_q ? in1_req_msg : in0_req_msg;

    assign out_req_val = in_issue;
    assign out_req_msg = in_issue ? req_q : '0;

    assign own_resp_rdy = owner_q ? in1_resp_rdy : in0_resp_rdy;
    assign out_resp_rdy = in_wait && own_resp_rdy;
    assign in0_resp_val = in_wait && !owner_q && out_resp_val;
    assign in1_resp_val = in_wait &&  owner_q && out_resp_val;
    assign in0_resp_msg = out_resp_msg;
    assign in1_resp_msg = out_resp_msg;
    assign resp_fire    = in_wait && out_resp_val && own_resp_rdy;

    // sd follows the owner for the whole L2 transaction, even across a slot boundary.
    assign sd = reset ? 1'b0 : ((state_q == IDLE) ? cur_dom_q : owner_q);

    assign dbg_state_o    = state_q;
    assign dbg_slot_cnt_o = slot_q;
    assign dbg_cur_dom_o  = cur_dom_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q    <= '0;
            cur_dom_q <= 1'b0;
            state_q   <= IDLE;
            req_q     <= '0;
            owner_q   <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            cur_dom_q <= cur_dom_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_q   <= cur_req_msg;
                        owner_q <= cur_dom_q;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (out_req_rdy) state_q <= WAIT;
                end
                WAIT: begin
                    if (resp_fire) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
